// File: rtl/isa_pkg.sv
// Shared ISA definitions for the front end: widths, opcode encodings and the
// predecoded jump-target rule used by the fetch stage.
package isa_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_LW  = 4'b1000,
        OP_SW  = 4'b1010,
        OP_BNE = 4'b1110,
        OP_JMP = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] fetch_pc;
        logic              fetch_valid;
    } fetch_state_t;

    // Region bits come from the sequential successor, so a jump in the last
    // word of a region lands in the following region.
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [ADDR_W-1:0]  fetch_pc,
        input logic [INSTR_W-1:0] instr
    );
        logic [ADDR_W-1:0] pc_seq;
        pc_seq = fetch_pc + PC_STEP;
        return {pc_seq[ADDR_W-1 -: 3], instr[11:0], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from execute/decode, instruction-memory port and
// the instruction handed to decode.
interface fetch_unit_if;
    import isa_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-state selection for the fetch stage: redirect, stall, predecoded jump,
// then sequential flow, in that priority.
module fetch_next_pc
    import isa_pkg::*;
(
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  fetch_pc_q,
    input  logic               fetch_valid_q,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  imem_addr,
    output fetch_state_t       nxt
);

    logic jump_hit;

    assign jump_hit = fetch_valid_q && (instr[15:12] == OP_JMP);

    always_comb begin
        nxt.pc          = pc + PC_STEP;
        nxt.fetch_pc    = pc;
        nxt.fetch_valid = 1'b1;
        if (redirect_valid) begin
            // Word fetched on this edge is wrong-path; drop it even when stalled.
            nxt.pc          = {redirect_pc[ADDR_W-1:1], 1'b0};
            nxt.fetch_pc    = imem_addr;
            nxt.fetch_valid = 1'b0;
        end else if (stall) begin
            nxt.pc          = pc;
            nxt.fetch_pc    = fetch_pc_q;
            nxt.fetch_valid = fetch_valid_q;
        end else if (jump_hit) begin
            nxt.pc          = jump_target(fetch_pc_q, instr);
            nxt.fetch_pc    = pc;
            nxt.fetch_valid = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives the instruction-memory address and
// pairs the returned word with its PC and valid flag for decode.
module fetch_unit
    import isa_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
)
(
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              fetch_valid_q;
    fetch_state_t      nxt;

    // A stall re-reads the held word so instr stays stable at the decode input.
    assign bus.imem_addr   = bus.stall ? fetch_pc_q : pc;
    assign bus.instr       = bus.imem_rdata;
    assign bus.instr_pc    = fetch_pc_q;
    assign bus.instr_valid = fetch_valid_q;

    fetch_next_pc u_next_pc (
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .stall          (bus.stall),
        .pc             (pc),
        .fetch_pc_q     (fetch_pc_q),
        .fetch_valid_q  (fetch_valid_q),
        .instr          (bus.imem_rdata),
        .imem_addr      (bus.imem_addr),
        .nxt            (nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            pc            <= nxt.pc;
            fetch_pc_q    <= nxt.fetch_pc;
            fetch_valid_q <= nxt.fetch_valid;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered instruction memory, directed scenarios and
// randomized stall/redirect traffic against an instruction-stream model.
module tb_fetch_unit;
    import isa_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic reset;
    fetch_unit_if bus();

    logic [15:0] mem [0:32767];
    int checks = 0;
    int errors = 0;

    // Model: expected current output and the next PC the stream should deliver
    logic        m_v;
    logic [15:0] m_p;
    logic [15:0] m_next;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[15:1]];

    function automatic logic [15:0] model_target(input logic [15:0] at, input logic [15:0] w);
        logic [15:0] succ;
        succ = at + 16'd2;
        return (succ & 16'hE000) | ((w & 16'h0FFF) << 1);
    endfunction

    task automatic fill_random(input bit allow_jumps);
        logic [15:0] w;
        for (int k = 0; k < 32768; k++) begin
            w = 16'($urandom);
            if (!allow_jumps && w[15:12] == 4'hF) w[15] = 1'b0;
            mem[k] = w;
        end
    endtask

    task automatic load_program();
        fill_random(1'b0);
        mem[0]  = 16'h2019;
        mem[1]  = 16'h634A;
        mem[2]  = 16'h048B;
        mem[3]  = 16'h0123;
        mem[4]  = 16'h757D;
        mem[5]  = 16'h2222;
        mem[6]  = 16'h6001;
        mem[7]  = 16'h8004;
        mem[8]  = 16'hA006;
        mem[9]  = 16'hF004;
        mem[10] = 16'h1234;
    endtask

    // Drive inputs for the coming edge and advance the model across it
    task automatic drive(input logic st, input logic rv, input logic [15:0] rpc);
        logic [15:0] w;
        bus.stall = st;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        w = mem[m_p[15:1]];
        if (rv) begin
            m_v = 1'b0;
            m_next = rpc & 16'hFFFE;
        end else if (st) begin
            m_v = m_v;
        end else if (m_v && w[15:12] == 4'hF) begin
            m_v = 1'b0;
            m_next = model_target(m_p, w);
        end else begin
            m_v = 1'b1;
            m_p = m_next;
            m_next = m_next + 16'd2;
        end
    endtask

    task automatic tick(input logic st, input logic rv, input logic [15:0] rpc);
        drive(st, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        m_v = 1'b0;
        m_p = 16'h0000;
        m_next = RESET_PC;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        load_program();
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        reset = 1'b1;
        #3;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 16'h0000 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset: valid=%0b pc=%h addr=%h, want valid=0 pc=0000 addr=%h",
                     bus.instr_valid, bus.instr_pc, bus.imem_addr, RESET_PC);
        end
        do_reset();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release: valid=%0b pc=%h, want valid=0 pc=0000",
                     bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_sequential_and_jump();
        for (int n = 1; n <= 12; n++) begin
            tick(1'b0, 1'b0, 16'h0000);
            checks++;
            if (bus.instr_valid !== m_v || (m_v && (bus.instr_pc !== m_p || bus.instr !== mem[m_p[15:1]]))) begin
                errors++;
                $display("FAIL seq[%0d]: valid=%0b pc=%h instr=%h, want valid=%0b pc=%h instr=%h",
                         n, bus.instr_valid, bus.instr_pc, bus.instr, m_v, m_p, mem[m_p[15:1]]);
            end
            if (n == 1 || n == 2 || n == 10 || n == 11 || n == 12) begin
                checks++;
                if ((n == 1  && (bus.instr_pc !== 16'h0000 || bus.instr !== 16'h2019 || bus.instr_valid !== 1'b1)) ||
                    (n == 2  && (bus.instr_pc !== 16'h0002 || bus.instr !== 16'h634A || bus.instr_valid !== 1'b1)) ||
                    (n == 10 && (bus.instr_pc !== 16'h0012 || bus.instr !== 16'hF004 || bus.instr_valid !== 1'b1)) ||
                    (n == 11 && bus.instr_valid !== 1'b0) ||
                    (n == 12 && (bus.instr_pc !== 16'h0008 || bus.instr !== 16'h757D || bus.instr_valid !== 1'b1))) begin
                    errors++;
                    $display("FAIL program_point[%0d]: valid=%0b pc=%h instr=%h",
                             n, bus.instr_valid, bus.instr_pc, bus.instr);
                end
            end
        end
    endtask

    task automatic test_stall();
        load_program();
        do_reset();
        for (int n = 0; n < 3; n++) tick(1'b0, 1'b0, 16'h0000);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b0, 16'h0000);
            #1;
            checks++;
            if (bus.imem_addr !== 16'h0004) begin
                errors++;
                $display("FAIL stall_addr[%0d]: addr=%h, want 0004", n, bus.imem_addr);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0004 || bus.instr !== 16'h048B) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%0b pc=%h instr=%h, want 1 0004 048B",
                         n, bus.instr_valid, bus.instr_pc, bus.instr);
            end
        end
        tick(1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0006 || bus.instr_pc !== m_p) begin
            errors++;
            $display("FAIL stall_resume: valid=%0b pc=%h, want 1 0006", bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_redirect();
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b1, 16'h0011);
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble: valid=%0b, want 0", bus.instr_valid);
        end
        drive(1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (bus.imem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL redirect_addr: addr=%h, want 0010", bus.imem_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0010 || bus.instr !== mem[8]) begin
            errors++;
            $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, want 1 0010 %h",
                     bus.instr_valid, bus.instr_pc, bus.instr, mem[8]);
        end
        tick(1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0012 || bus.instr !== 16'hF004) begin
            errors++;
            $display("FAIL redirect_follow: valid=%0b pc=%h instr=%h, want 1 0012 F004",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_redirect_over_jump();
        tick(1'b1, 1'b1, 16'h000C);
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rj_bubble: valid=%0b, want 0", bus.instr_valid);
        end
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 1'b0, 16'h0000);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h000C + 16'(2 * n) || bus.instr_pc !== m_p ||
                bus.instr !== mem[m_p[15:1]]) begin
                errors++;
                $display("FAIL rj_stream[%0d]: valid=%0b pc=%h instr=%h, want 1 %h %h",
                         n, bus.instr_valid, bus.instr_pc, bus.instr, m_p, mem[m_p[15:1]]);
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        mem[16'h7FFF] = 16'h0ABC;
        tick(1'b0, 1'b1, 16'hFFFF);
        for (int n = 0; n < 2; n++) begin
            tick(1'b0, 1'b0, 16'h0000);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== (n == 0 ? 16'hFFFE : 16'h0000) ||
                bus.instr !== mem[m_p[15:1]]) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%0b pc=%h instr=%h, want 1 %h %h",
                         n, bus.instr_valid, bus.instr_pc, bus.instr, m_p, mem[m_p[15:1]]);
            end
        end
        drive(1'b1, 1'b0, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        bus.stall = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 16'h0000 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL async_reset: valid=%0b pc=%h addr=%h, want 0 0000 %h",
                     bus.instr_valid, bus.instr_pc, bus.imem_addr, RESET_PC);
        end
        do_reset();
        tick(1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RESET_PC || bus.instr !== mem[RESET_PC[15:1]]) begin
            errors++;
            $display("FAIL post_reset_fetch: valid=%0b pc=%h instr=%h, want 1 %h",
                     bus.instr_valid, bus.instr_pc, bus.instr, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic st, rv;
        fill_random(1'b1);
        do_reset();
        for (int n = 0; n < 600; n++) begin
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 15) == 0);
            tick(st, rv, 16'($urandom));
            checks++;
            if (bus.instr_valid !== m_v || (m_v && (bus.instr_pc !== m_p || bus.instr !== mem[m_p[15:1]]))) begin
                errors++;
                $display("FAIL random[%0d]: valid=%0b pc=%h instr=%h, want valid=%0b pc=%h instr=%h",
                         n, bus.instr_valid, bus.instr_pc, bus.instr, m_v, m_p, mem[m_p[15:1]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential_and_jump();
        test_stall();
        test_redirect();
        test_redirect_over_jump();
        test_wrap_and_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
